pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Consumer of the hazard unit's stall/flush/forward-side requests. Owns the fetch PC register and turns hazard requests, decode-stage branch/jump redirects and data-memory wait states into per-stage register enables and flushes for the five-stage pipeline. Sits between the hazard unit, the decode-stage branch comparator, the data memory and the F/D, D/E, E/M and M/W pipeline registers. Also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- ADDR_WIDTH, 32, PC and target width.
- CNT_WIDTH, 16, width of each performance counter.
- MEM_TIMEOUT, 64, maximum consecutive memory wait cycles before the timeout flag is set.

Ports:
- iClk  in  1  Clock. Single clock domain; all state updates on the rising edge.
- iRst  in  1  Reset. Synchronous, active-high.
- iStallF  in  1  Fetch stall request from the hazard unit.
- iStallD  in  1  Decode stall request from the hazard unit.
- iFlushE  in  1  Execute bubble request from the hazard unit.
- iRedirectD  in  1  Taken branch, JAL or JALR resolved in decode.
- iTargetD  in  ADDR_WIDTH  Redirect target.
- iMemReqM  in  1  Load or store occupying the memory stage.
- iMemReadyM  in  1  Data memory completes the access this cycle.
- oPcF  out  ADDR_WIDTH  Current fetch PC.
- oEnF / oEnD / oEnE / oEnM  out  1 each  Enables for the PC, F/D, D/E and E/M registers.
- oFlushD / oFlushE / oFlushW  out  1 each  Synchronous clears for the F/D, D/E and M/W registers.
- oMisalignedTarget  out  1  One-cycle pulse when an accepted redirect has iTargetD[1:0] != 0.
- oMemTimeout  out  1  Sticky flag; cleared only by reset.
- oStallCount / oFlushCount  out  CNT_WIDTH each  Saturating event counters.

## Operation
- FSM states: RUN and MEM_WAIT. Reset state is RUN.
- Define memFreeze = iMemReqM & ~iMemReadyM. This term is combinational and applies in both states.
- Priority is highest first.
- Priority 1, memFreeze:
  - All enables are 0 and oFlushW = 1.
  - Hazard requests and redirects are ignored; they are re-presented next cycle.
  - From RUN the next state is MEM_WAIT. MEM_WAIT holds while memFreeze is set.
- Priority 2, hazard stall (iStallF | iStallD):
  - oEnF = 0, oEnD = 0, oEnE = 1, oEnM = 1.
  - oFlushE = iFlushE.
  - The redirect is suppressed, because branch operands are not ready yet.
- Priority 3, iRedirectD:
  - PC <= {iTargetD[ADDR_WIDTH-1:2], 2'b00}.
  - oFlushD = 1, squashing the wrong-path fetch.
  - oMisalignedTarget pulses if iTargetD[1:0] != 0.
  - If iFlushE is also asserted, honour it as well.
- Otherwise: PC <= PC + 4 with wrap-around modulo 2^ADDR_WIDTH, and all enables are 1.
- In every state where memFreeze is not asserted, oFlushE = iFlushE.
- MEM_WAIT exits to RUN on the cycle iMemReadyM = 1. Enables are high in that same cycle.
- Wait counter:
  - Increments each MEM_WAIT cycle and clears on entry to RUN.
  - When it reaches MEM_TIMEOUT, oMemTimeout sets. The block stays in MEM_WAIT; it does not force progress.
- oStallCount increments once per cycle in which oEnF = 0.
- oFlushCount increments once per cycle in which oFlushD or oFlushE is asserted.
- Both counters saturate at all-ones.

## Timing
- Reset values:
  - oPcF = RESET_PC, FSM = RUN.
  - Wait counter, both performance counters and oMemTimeout = 0.
  - oMisalignedTarget = 0.
  - Enables are 1 and flushes are 0 while iRst is high, provided inputs are idle. The PC still loads RESET_PC on every reset cycle.
- All enable and flush outputs are combinational from the current inputs and state: zero latency, so they act on the same clock edge.
- oPcF updates one cycle after the decision.
- Redirect penalty is one bubble (oFlushD).
- Load-use stall costs one cycle per cycle of iStallD.
- Reset asserted mid-MEM_WAIT returns to RUN at RESET_PC on the next edge, regardless of iMemReadyM.
- Simultaneous memFreeze, stall and redirect: only the memFreeze behaviour applies and oFlushE = 0.

## Structure
- Add the FSM enum (RUN, MEM_WAIT) and a PC_STEP constant (4) to the shared control typedefs package, next to the existing instruction type enums.
- One natural sub-module: sat_counter (parameter CNT_WIDTH; inputs inc, clear). Instantiate it twice for the performance counters and once for the wait counter.
- The PC register and the FSM stay in the top level.

## Test plan
- Reset, then 3 idle cycles -> oPcF steps RESET_PC, +4, +8, +12; all enables 1, all flushes 0.
- iStallF = iStallD = iFlushE = 1 for 1 cycle at PC 0x100 -> oEnF = oEnD = 0, oFlushE = 1, PC holds at 0x100, oStallCount = 1.
- iRedirectD = 1 with iTargetD = 0x206 -> next oPcF = 0x204, oFlushD = 1, oMisalignedTarget pulses, oFlushCount increments.
- iMemReqM = 1, iMemReadyM low for 3 cycles then high:
  - Enables are 0 and oFlushW = 1 for 3 cycles; FSM returns to RUN on the 4th cycle with enables 1.
  - A redirect asserted during the wait is ignored.
- iMemReadyM held low for MEM_TIMEOUT cycles -> oMemTimeout = 1 and stays set; cleared only by iRst.
- Preload oStallCount near saturation (CNT_WIDTH = 4, 20 stall cycles) -> counter holds 4'hF.
- Assert iRst mid-MEM_WAIT -> next cycle oPcF = RESET_PC, FSM = RUN, counters 0.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared control typedefs for the five-stage pipeline: instruction classes, controller FSM, PC step.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pipeline_controller_pkg;

  // Instruction format classes used by decode.
  typedef enum logic [2:0] {
    INSTR_R,
    INSTR_I,
    INSTR_S,
    INSTR_B,
    INSTR_U,
    INSTR_J
  } instrType_t;

  // Pipeline controller states: normal flow, or frozen behind a slow data-memory access.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrlState_t;

  // Byte distance between sequential fetches.
  localparam int PC_STEP = 4;

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter: holds at all-ones, clear has priority over increment.
// Latency: count reflects inc/clear one cycle after they are presented.
// Backpressure: none; an increment at all-ones is dropped.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 iClk,
  input  logic                 inc,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] count
);

  // Clear wins; otherwise step up until every bit is set, then hold.
  always_ff @(posedge iClk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Fetch PC owner and stage enable/flush generator: memory freeze > hazard stall > decode redirect > advance.
// Latency: enables/flushes combinational (act on the same edge); oPcF updates one cycle after the decision.
// Backpressure: an unfinished memory access freezes every stage; stall/redirect are ignored and must be re-presented.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'hBFC0_0000,
  parameter int                    CNT_WIDTH   = 16,
  parameter int                    MEM_TIMEOUT = 64
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iStallF,
  input  logic                  iStallD,
  input  logic                  iFlushE,
  input  logic                  iRedirectD,
  input  logic [ADDR_WIDTH-1:0] iTargetD,
  input  logic                  iMemReqM,
  input  logic                  iMemReadyM,
  output logic [ADDR_WIDTH-1:0] oPcF,
  output logic                  oEnF,
  output logic                  oEnD,
  output logic                  oEnE,
  output logic                  oEnM,
  output logic                  oFlushD,
  output logic                  oFlushE,
  output logic                  oFlushW,
  output logic                  oMisalignedTarget,
  output logic                  oMemTimeout,
  output logic [CNT_WIDTH-1:0]  oStallCount,
  output logic [CNT_WIDTH-1:0]  oFlushCount
);

  // Wide enough to represent MEM_TIMEOUT itself.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrlState_t        state;
  ctrlState_t        nextState;
  logic              memFreeze;
  logic              hazardStall;
  logic              takeRedirect;
  logic              waitClear;
  logic [WAIT_W-1:0] waitCnt;

  assign memFreeze   = iMemReqM & ~iMemReadyM;
  assign hazardStall = iStallF | iStallD;

  // State register; reset always lands in RUN regardless of the memory handshake.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Next state and per-stage enables/flushes, resolved in priority order.
  always_comb begin
    nextState         = state;
    oEnF              = 1'b1;
    oEnD              = 1'b1;
    oEnE              = 1'b1;
    oEnM              = 1'b1;
    oFlushD           = 1'b0;
    oFlushE           = 1'b0;
    oFlushW           = 1'b0;
    oMisalignedTarget = 1'b0;
    takeRedirect      = 1'b0;

    case (state)
      RUN:      if (memFreeze)  nextState = MEM_WAIT;
      MEM_WAIT: if (!memFreeze) nextState = RUN;
      default:  nextState = RUN;
    endcase

    if (memFreeze) begin
      // Whole pipe holds; a bubble drains into writeback so the stuck access retires only once.
      oEnF    = 1'b0;
      oEnD    = 1'b0;
      oEnE    = 1'b0;
      oEnM    = 1'b0;
      oFlushW = 1'b1;
    end else begin
      oFlushE = iFlushE;
      if (hazardStall) begin
        // Branch operands may not be ready, so any redirect waits for the stall to clear.
        oEnF = 1'b0;
        oEnD = 1'b0;
      end else if (iRedirectD) begin
        takeRedirect      = 1'b1;
        oFlushD           = 1'b1;
        oMisalignedTarget = |iTargetD[1:0];
      end
    end
  end

  // Fetch PC: word-aligned redirect target or sequential step, held whenever fetch is disabled.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oPcF <= RESET_PC;
    end else if (oEnF) begin
      if (takeRedirect) begin
        oPcF <= {iTargetD[ADDR_WIDTH-1:2], 2'b00};
      end else begin
        oPcF <= oPcF + ADDR_WIDTH'(PC_STEP);
      end
    end
  end

  // Sticky timeout: set on the edge where the frozen-cycle count reaches MEM_TIMEOUT.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oMemTimeout <= 1'b0;
    end else if (memFreeze && (waitCnt == WAIT_W'(MEM_TIMEOUT - 1))) begin
      oMemTimeout <= 1'b1;
    end
  end

  // The wait count includes the frozen cycle that enters MEM_WAIT and restarts whenever RUN resumes.
  assign waitClear = iRst | (nextState == RUN);

  sat_counter #(.CNT_WIDTH(WAIT_W)) uWaitCnt (
    .iClk  (iClk),
    .inc   (memFreeze),
    .clear (waitClear),
    .count (waitCnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uStallCnt (
    .iClk  (iClk),
    .inc   (~oEnF),
    .clear (iRst),
    .count (oStallCount)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uFlushCnt (
    .iClk  (iClk),
    .inc   (oFlushD | oFlushE),
    .clear (iRst),
    .count (oFlushCount)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: per-cycle rule model plus directed literal checks.
// Latency: model expects enables/flushes in the same cycle and PC/counters one edge later.
// Backpressure: memory freeze vectors exercise the hold, timeout and reset-escape paths.
module tb_pipeline_controller;

  localparam int          AW  = 32;
  localparam int          CW  = 4;
  localparam int          MT  = 64;
  localparam logic [31:0] RPC = 32'hBFC0_0000;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          stallF;
  logic          stallD;
  logic          flushEIn;
  logic          redirect;
  logic [AW-1:0] target;
  logic          memReq;
  logic          memReady;

  logic [AW-1:0] pcF;
  logic          enF, enD, enE, enM;
  logic          flushD, flushE, flushW;
  logic          misaligned;
  logic          memTimeout;
  logic [CW-1:0] stallCount;
  logic [CW-1:0] flushCount;

  int total = 0;
  int bad   = 0;

  pipeline_controller #(
    .ADDR_WIDTH  (AW),
    .RESET_PC    (RPC),
    .CNT_WIDTH   (CW),
    .MEM_TIMEOUT (MT)
  ) dut (
    .iClk              (clk),
    .iRst              (rst),
    .iStallF           (stallF),
    .iStallD           (stallD),
    .iFlushE           (flushEIn),
    .iRedirectD        (redirect),
    .iTargetD          (target),
    .iMemReqM          (memReq),
    .iMemReadyM        (memReady),
    .oPcF              (pcF),
    .oEnF              (enF),
    .oEnD              (enD),
    .oEnE              (enE),
    .oEnM              (enM),
    .oFlushD           (flushD),
    .oFlushE           (flushE),
    .oFlushW           (flushW),
    .oMisalignedTarget (misaligned),
    .oMemTimeout       (memTimeout),
    .oStallCount       (stallCount),
    .oFlushCount       (flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mPc;
  int          mWaitRun;
  bit          mTmo;
  int          mStall;
  int          mFlush;
  bit          mValid = 1'b0;

  // Compare at the falling edge, then advance the model with the inputs the next rising edge will see.
  always @(negedge clk) begin
    int rule;
    bit eEnF, eEnD, eEnE, eEnM, eFlD, eFlE, eFlW, eMis;
    // 1 = memory freeze, 2 = hazard stall, 3 = redirect, 4 = advance
    if (memReq && !memReady)      rule = 1;
    else if (stallF || stallD)    rule = 2;
    else if (redirect)            rule = 3;
    else                          rule = 4;

    eEnF = (rule >= 3);
    eEnD = (rule >= 3);
    eEnE = (rule != 1);
    eEnM = (rule != 1);
    eFlW = (rule == 1);
    eFlE = (rule != 1) && flushEIn;
    eFlD = (rule == 3);
    eMis = (rule == 3) && (target[1:0] != 2'b00);

    if (mValid) begin
      check("pcF",        pcF,        mPc);
      check("enF",        enF,        eEnF);
      check("enD",        enD,        eEnD);
      check("enE",        enE,        eEnE);
      check("enM",        enM,        eEnM);
      check("flushD",     flushD,     eFlD);
      check("flushE",     flushE,     eFlE);
      check("flushW",     flushW,     eFlW);
      check("misaligned", misaligned, eMis);
      check("memTimeout", memTimeout, mTmo);
      check("stallCount", stallCount, mStall);
      check("flushCount", flushCount, mFlush);
    end

    if (rst) begin
      mPc      = RPC;
      mWaitRun = 0;
      mTmo     = 1'b0;
      mStall   = 0;
      mFlush   = 0;
      mValid   = 1'b1;
    end else if (mValid) begin
      if (rule == 3)      mPc = {target[31:2], 2'b00};
      else if (rule == 4) mPc = mPc + 32'd4;
      if (!eEnF && mStall < CNT_MAX)            mStall++;
      if ((eFlD || eFlE) && mFlush < CNT_MAX)   mFlush++;
      mWaitRun = (rule == 1) ? mWaitRun + 1 : 0;
      if (mWaitRun >= MT) mTmo = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    stallF = 0; stallD = 0; flushEIn = 0; redirect = 0;
    target = '0; memReq = 0; memReady = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("rst_pc",     pcF,        RPC);
    check("rst_stall",  stallCount, 0);
    check("rst_flush",  flushCount, 0);
    check("rst_tmo",    memTimeout, 0);
    check("rst_enF",    enF,        1);
    tick(); settle(); check("seq_pc4",  pcF, RPC + 32'd4);
    tick(); settle(); check("seq_pc8",  pcF, RPC + 32'd8);
    tick(); settle(); check("seq_pc12", pcF, RPC + 32'd12);

    // Aligned redirect to 0x100, then a combined stall + execute flush there.
    redirect = 1; target = 32'h100;
    settle(); check("redir_flushD", flushD, 1);
    tick(); idle();
    stallF = 1; stallD = 1; flushEIn = 1;
    settle();
    check("stall_pc",     pcF,    32'h100);
    check("stall_enF",    enF,    0);
    check("stall_enD",    enD,    0);
    check("stall_flushE", flushE, 1);
    tick(); idle();
    settle();
    check("stall_hold_pc", pcF,        32'h100);
    check("stall_cnt1",    stallCount, 1);
    check("flush_cnt2",    flushCount, 2);

    // Misaligned redirect target is word-aligned and flagged.
    redirect = 1; target = 32'h206;
    settle();
    check("mis_flushD", flushD,     1);
    check("mis_pulse",  misaligned, 1);
    tick(); idle();
    settle();
    check("mis_pc",      pcF,        32'h204);
    check("mis_cleared", misaligned, 0);
    check("flush_cnt3",  flushCount, 3);

    // Redirect under a hazard stall is suppressed.
    stallD = 1; redirect = 1; target = 32'h400;
    settle();
    check("stallredir_flushD", flushD, 0);
    tick(); idle();
    settle();
    check("stallredir_pc", pcF, 32'h204);

    // Memory freeze for 3 cycles with stall, flush and redirect all raised.
    memReq = 1; memReady = 0; stallD = 1; flushEIn = 1; redirect = 1; target = 32'h500;
    settle();
    check("frz_enE",    enE,    0);
    check("frz_flushW", flushW, 1);
    check("frz_flushE", flushE, 0);
    check("frz_flushD", flushD, 0);
    tick(); tick(); tick();
    stallD = 0; flushEIn = 0; redirect = 0; memReady = 1;
    settle();
    check("frz_exit_enF", enF, 1);
    check("frz_exit_pc",  pcF, 32'h204);
    tick(); idle();
    settle();
    check("frz_after_pc", pcF,        32'h208);
    check("stall_cnt5",   stallCount, 5);

    // 20 stall cycles drive the 4-bit stall counter into saturation.
    stallD = 1;
    for (int i = 0; i < 20; i++) tick();
    idle();
    settle();
    check("stall_sat", stallCount, 4'hF);

    // Memory held off for exactly MEM_TIMEOUT cycles sets the sticky timeout.
    memReq = 1; memReady = 0;
    for (int i = 0; i < MT - 1; i++) tick();
    settle();
    check("tmo_before", memTimeout, 0);
    tick();
    settle();
    check("tmo_set", memTimeout, 1);
    memReady = 1;
    tick(); idle();
    tick(); tick();
    settle();
    check("tmo_sticky", memTimeout, 1);

    // Reset in the middle of a memory wait.
    memReq = 1; memReady = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0; idle();
    settle();
    check("midrst_pc",    pcF,        RPC);
    check("midrst_stall", stallCount, 0);
    check("midrst_flush", flushCount, 0);
    check("midrst_tmo",   memTimeout, 0);
    check("midrst_enF",   enF,        1);

    // Short freeze after reset must not trip the timeout again.
    memReq = 1; memReady = 0;
    for (int i = 0; i < 5; i++) tick();
    idle();
    tick(); tick();
    settle();
    check("short_frz_tmo", memTimeout, 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
